// File: rtl/lfsr_burst_ctrl.sv
// Burst sequencer for a serial LFSR: drives enable/clear, packs the bit stream
// MSB-first into WORD_W-bit words and delivers them over a valid/ready handshake.
module lfsr_burst_ctrl #(
    parameter int WORD_W = 8,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              res,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              restart,
    output logic              busy,
    output logic              done,
    output logic              lfsr_enable,
    output logic              lfsr_clear,
    input  logic              lfsr_bit,
    output logic              word_valid,
    output logic [WORD_W-1:0] word_data,
    input  logic              word_ready
);

    localparam int CNT_W = $clog2(WORD_W + 1);

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        RUN,
        DRAIN
    } state_t;

    state_t            state;
    logic [WORD_W-1:0] acc;
    logic [CNT_W-1:0]  bitcnt;
    logic [LEN_W-1:0]  remaining;

    logic              slot_free;
    logic              last_bit;
    logic              word_end;
    logic [WORD_W-1:0] acc_next;

    // The LFSR is held only when the next capture would need an output slot
    // that is still occupied; enable therefore follows word_ready combinationally.
    always_comb begin
        slot_free   = !word_valid || word_ready;
        last_bit    = (remaining == LEN_W'(1));
        word_end    = (bitcnt == CNT_W'(WORD_W - 1)) || last_bit;
        acc_next    = {acc[WORD_W-2:0], lfsr_bit};
        lfsr_enable = (state == RUN) && !(word_end && !slot_free);
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state      <= IDLE;
            acc        <= '0;
            bitcnt     <= '0;
            remaining  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            lfsr_clear <= 1'b0;
            word_valid <= 1'b0;
            word_data  <= '0;
        end else begin
            done <= 1'b0;
            if (word_valid && word_ready) begin
                word_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        if (len != '0) begin
                            remaining <= len;
                            acc       <= '0;
                            bitcnt    <= '0;
                            busy      <= 1'b1;
                            if (restart) begin
                                state      <= CLEAR;
                                lfsr_clear <= 1'b1;
                            end else begin
                                state <= RUN;
                            end
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end

                CLEAR: begin
                    lfsr_clear <= 1'b0;
                    state      <= RUN;
                end

                RUN: begin
                    if (lfsr_enable) begin
                        remaining <= remaining - LEN_W'(1);
                        if (word_end) begin
                            word_data  <= acc_next;
                            word_valid <= 1'b1;
                            acc        <= '0;
                            bitcnt     <= '0;
                        end else begin
                            acc    <= acc_next;
                            bitcnt <= bitcnt + CNT_W'(1);
                        end
                        if (last_bit) begin
                            state <= DRAIN;
                        end
                    end
                end

                DRAIN: begin
                    if (word_valid && word_ready) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_burst_ctrl.sv
// Bench for lfsr_burst_ctrl with a 3-bit Galois LFSR (taps 3'b111, all-ones seed)
// as the bit source; its output repeats 1,0,0,1 so full words read 0x99.
module tb_lfsr_burst_ctrl;

    logic       clk;
    logic       res;
    logic       start;
    logic [7:0] len;
    logic       restart;
    logic       busy;
    logic       done;
    logic       lfsr_enable;
    logic       lfsr_clear;
    logic       lfsr_bit;
    logic       word_valid;
    logic [7:0] word_data;
    logic       word_ready;

    lfsr_burst_ctrl #(.WORD_W(8), .LEN_W(8)) dut (
        .clk        (clk),
        .res        (res),
        .start      (start),
        .len        (len),
        .restart    (restart),
        .busy       (busy),
        .done       (done),
        .lfsr_enable(lfsr_enable),
        .lfsr_clear (lfsr_clear),
        .lfsr_bit   (lfsr_bit),
        .word_valid (word_valid),
        .word_data  (word_data),
        .word_ready (word_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // LFSR environment: reset and clear both load the all-ones seed.
    logic [2:0] lfsr_s = 3'b111;
    always @(posedge clk) begin
        if (res || lfsr_clear)
            lfsr_s <= 3'b111;
        else if (lfsr_enable)
            lfsr_s <= lfsr_s[0] ? ((lfsr_s >> 1) ^ 3'b111) : (lfsr_s >> 1);
    end
    assign lfsr_bit = lfsr_s[0];

    // Mid-cycle monitor: enables, done pulses, valid cycles, handshaked words.
    int         en_cnt   = 0;
    int         done_cnt = 0;
    int         wv_cnt   = 0;
    int         overlap  = 0;
    logic [7:0] words[$];
    always @(negedge clk) begin
        if (!res) begin
            if (lfsr_enable) en_cnt++;
            if (done) done_cnt++;
            if (word_valid) wv_cnt++;
            if (lfsr_enable && lfsr_clear) overlap++;
            if (word_valid && word_ready) words.push_back(word_data);
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int word_at(input int i);
        return (i < words.size()) ? int'(words[i]) : -1;
    endfunction

    task automatic start_burst(input logic [7:0] l, input logic r);
        start   = 1'b1;
        len     = l;
        restart = r;
        @(posedge clk); #1;
        start   = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); #1;
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        chk({name, "_done_seen"}, 32'(seen), 32'd1);
    endtask

    typedef struct {
        logic       start;
        logic [7:0] len;
        logic       restart;
        logic       ready;
        logic       busy;
        logic       done;
        logic       en;
        logic       clr;
        logic       wv;
        logic [7:0] wd;
    } vec_t;

    function automatic vec_t mk(logic s, logic [7:0] l, logic r, logic rd,
                                logic b, logic d, logic e, logic c, logic v, logic [7:0] w);
        vec_t t;
        t = '{start:s, len:l, restart:r, ready:rd, busy:b, done:d, en:e, clr:c, wv:v, wd:w};
        return t;
    endfunction

    vec_t tbl[13];

    initial begin
        int en_b, w_b, wv_b, d_b, unstable;

        // One burst of 8 bits with restart, cycle by cycle from the start cycle.
        tbl[0] = mk(1, 8, 1, 1, 0, 0, 0, 0, 0, 8'h00);
        tbl[1] = mk(0, 0, 0, 1, 1, 0, 0, 1, 0, 8'h00);
        for (int i = 2; i < 10; i++)
            tbl[i] = mk(0, 0, 0, 1, 1, 0, 1, 0, 0, 8'h00);
        tbl[10] = mk(0, 0, 0, 1, 1, 0, 0, 0, 1, 8'h99);
        tbl[11] = mk(0, 0, 0, 1, 0, 1, 0, 0, 0, 8'h99);
        tbl[12] = mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 8'h99);

        res = 1'b1; start = 1'b0; len = '0; restart = 1'b0; word_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 res = 1'b0;

        en_b = en_cnt; w_b = words.size();
        for (int i = 0; i < 13; i++) begin
            start = tbl[i].start; len = tbl[i].len;
            restart = tbl[i].restart; word_ready = tbl[i].ready;
            @(negedge clk); #1;
            chk($sformatf("t1_c%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
            chk($sformatf("t1_c%0d_done", i), 32'(done), 32'(tbl[i].done));
            chk($sformatf("t1_c%0d_en", i), 32'(lfsr_enable), 32'(tbl[i].en));
            chk($sformatf("t1_c%0d_clr", i), 32'(lfsr_clear), 32'(tbl[i].clr));
            chk($sformatf("t1_c%0d_wv", i), 32'(word_valid), 32'(tbl[i].wv));
            chk($sformatf("t1_c%0d_wd", i), 32'(word_data), 32'(tbl[i].wd));
            @(posedge clk); #1;
        end
        chk("t1_enables", 32'(en_cnt - en_b), 32'd8);
        chk("t1_words", 32'(words.size() - w_b), 32'd1);
        chk("t1_word0", 32'(word_at(w_b)), 32'h99);

        // 12 bits: a full word followed by a 4-bit partial word in the LSBs.
        en_b = en_cnt; w_b = words.size(); wv_b = wv_cnt;
        start_burst(8'd12, 1'b1);
        wait_done("t2");
        chk("t2_words", 32'(words.size() - w_b), 32'd2);
        chk("t2_word0", 32'(word_at(w_b)), 32'h99);
        chk("t2_word1", 32'(word_at(w_b + 1)), 32'h09);
        chk("t2_enables", 32'(en_cnt - en_b), 32'd12);
        chk("t2_valid_cycles", 32'(wv_cnt - wv_b), 32'd2);

        // 16 bits against a blocked consumer: stall before bit 16.
        @(posedge clk); #1;
        en_b = en_cnt; w_b = words.size(); unstable = 0;
        word_ready = 1'b0;
        start_burst(8'd16, 1'b1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            if (word_valid && word_data !== 8'h99) unstable++;
            @(posedge clk); #1;
        end
        @(negedge clk); #1;
        chk("t3_stall_enables", 32'(en_cnt - en_b), 32'd15);
        chk("t3_stall_en", 32'(lfsr_enable), 32'd0);
        chk("t3_stall_wv", 32'(word_valid), 32'd1);
        chk("t3_stall_wd", 32'(word_data), 32'h99);
        chk("t3_unstable", 32'(unstable), 32'd0);
        chk("t3_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        word_ready = 1'b1;
        wait_done("t3");
        chk("t3_words", 32'(words.size() - w_b), 32'd2);
        chk("t3_word0", 32'(word_at(w_b)), 32'h99);
        chk("t3_word1", 32'(word_at(w_b + 1)), 32'h99);
        chk("t3_enables", 32'(en_cnt - en_b), 32'd16);

        // Zero-length request: done pulse only.
        en_b = en_cnt; d_b = done_cnt; wv_b = wv_cnt;
        start_burst(8'd0, 1'b0);
        @(negedge clk); #1;
        chk("t4_done", 32'(done), 32'd1);
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_en", 32'(lfsr_enable), 32'd0);
        chk("t4_wv", 32'(word_valid), 32'd0);
        @(posedge clk); #1;
        @(negedge clk); #1;
        chk("t4_done_next", 32'(done), 32'd0);
        chk("t4_busy_next", 32'(busy), 32'd0);
        chk("t4_done_count", 32'(done_cnt - d_b), 32'd1);
        chk("t4_enables", 32'(en_cnt - en_b), 32'd0);
        chk("t4_valid_cycles", 32'(wv_cnt - wv_b), 32'd0);

        // Reset mid-burst after the fifth bit is presented.
        @(posedge clk); #1;
        en_b = en_cnt;
        start_burst(8'd8, 1'b1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            if (en_cnt - en_b >= 5) break;
            @(posedge clk); #1;
        end
        chk("t5_reached_bit5", 32'(en_cnt - en_b), 32'd5);
        res = 1'b1;
        @(posedge clk); #1;
        res = 1'b0;
        @(negedge clk); #1;
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_done", 32'(done), 32'd0);
        chk("t5_rst_en", 32'(lfsr_enable), 32'd0);
        chk("t5_rst_clr", 32'(lfsr_clear), 32'd0);
        chk("t5_rst_wv", 32'(word_valid), 32'd0);
        chk("t5_rst_wd", 32'(word_data), 32'd0);
        @(posedge clk); #1;
        en_b = en_cnt; w_b = words.size();
        start_burst(8'd8, 1'b1);
        wait_done("t5");
        chk("t5_words", 32'(words.size() - w_b), 32'd1);
        chk("t5_word0", 32'(word_at(w_b)), 32'h99);
        chk("t5_enables", 32'(en_cnt - en_b), 32'd8);

        // Start pulses during a burst are ignored; back-to-back burst continues the LFSR.
        @(posedge clk); #1;
        en_b = en_cnt; w_b = words.size(); d_b = done_cnt;
        start_burst(8'd8, 1'b1);
        repeat (2) begin @(posedge clk); #1; end
        start = 1'b1; len = 8'd3; restart = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        start = 1'b0;
        wait_done("t6a");
        chk("t6a_done_count", 32'(done_cnt - d_b), 32'd1);
        chk("t6a_enables", 32'(en_cnt - en_b), 32'd8);
        start_burst(8'd8, 1'b0);
        @(negedge clk); #1;
        chk("t6b_busy", 32'(busy), 32'd1);
        chk("t6b_clr", 32'(lfsr_clear), 32'd0);
        chk("t6b_en", 32'(lfsr_enable), 32'd1);
        @(posedge clk); #1;
        wait_done("t6b");
        chk("t6_done_count", 32'(done_cnt - d_b), 32'd2);
        chk("t6_words", 32'(words.size() - w_b), 32'd2);
        chk("t6_word0", 32'(word_at(w_b)), 32'h99);
        chk("t6_word1", 32'(word_at(w_b + 1)), 32'h99);
        chk("t6_enables", 32'(en_cnt - en_b), 32'd16);

        chk("clear_enable_overlap", 32'(overlap), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
